// File: rtl/btn_cfg_sequencer_if.sv
// Button-event and committed-configuration bundle for btn_cfg_sequencer.
// The master drives debounced press pulses; the slave returns registered settings.
interface btn_cfg_sequencer_if #(
  parameter int unsigned FREQ_W = 16
);
  logic              ev_mode;
  logic              ev_ok;
  logic              ev_up;
  logic              ev_down;
  logic [1:0]        wave_sel;
  logic [FREQ_W-1:0] freq_word;
  logic [3:0]        amp;
  logic [1:0]        focus;
  logic              dirty;
  logic              cfg_valid;

  modport master (
    output ev_mode, ev_ok, ev_up, ev_down,
    input  wave_sel, freq_word, amp, focus, dirty, cfg_valid
  );

  modport slave (
    input  ev_mode, ev_ok, ev_up, ev_down,
    output wave_sel, freq_word, amp, focus, dirty, cfg_valid
  );
endinterface

// File: rtl/btn_cfg_sequencer.sv
// Front-panel settings sequencer: button pulses edit shadow waveform/frequency/amplitude
// fields and an explicit OK commits them to the registered outputs.
module btn_cfg_sequencer #(
  parameter int unsigned       FREQ_W    = 16,
  parameter logic [FREQ_W-1:0] FREQ_MIN  = 16'd10,
  parameter logic [FREQ_W-1:0] FREQ_MAX  = 16'd50000,
  parameter logic [FREQ_W-1:0] FREQ_INIT = 16'd1000,
  parameter logic [FREQ_W-1:0] STEP      = 16'd10,
  parameter logic [23:0]       ACCEL_WIN = 24'd5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  btn_cfg_sequencer_if.slave  bus
);

  localparam int unsigned XW = FREQ_W + 3;

  typedef enum logic [1:0] {
    FOCUS_WAVE = 2'd0,
    FOCUS_FREQ = 2'd1,
    FOCUS_AMP  = 2'd2
  } focus_e;

  focus_e            state_q, state_d;
  logic [1:0]        wave_sh_q, wave_sh_d, wave_q, wave_d;
  logic [FREQ_W-1:0] freq_sh_q, freq_sh_d, freq_q, freq_d;
  logic [3:0]        amp_sh_q, amp_sh_d, amp_q, amp_d;
  logic              dirty_q, cfg_valid_q, cfg_valid_d;
  logic [23:0]       gap_q, gap_d;
  logic              last_up_q, last_up_d;

  logic              acc_mode, acc_ok, acc_up, acc_dn, freq_ev, accel;
  logic [XW-1:0]     step_x, sum_x, diff_x;
  logic [FREQ_W-1:0] freq_step;

  always_comb begin
    acc_mode = bus.ev_mode;
    acc_ok   = bus.ev_ok & ~bus.ev_mode;
    acc_up   = bus.ev_up & ~bus.ev_mode & ~bus.ev_ok;
    acc_dn   = bus.ev_down & ~bus.ev_mode & ~bus.ev_ok & ~bus.ev_up;
    freq_ev  = (state_q == FOCUS_FREQ) & (acc_up | acc_dn);

    // Repeated presses in the same direction inside the window move four times faster.
    accel  = (acc_up == last_up_q) && (gap_q < ACCEL_WIN);
    step_x = accel ? (XW'(STEP) << 2) : XW'(STEP);
    sum_x  = XW'(freq_sh_q) + step_x;
    diff_x = XW'(freq_sh_q) - step_x;
    if (acc_up) begin
      freq_step = (sum_x > XW'(FREQ_MAX)) ? FREQ_MAX : sum_x[FREQ_W-1:0];
    end else begin
      freq_step = (diff_x[XW-1] || (diff_x < XW'(FREQ_MIN))) ? FREQ_MIN : diff_x[FREQ_W-1:0];
    end

    state_d     = state_q;
    wave_sh_d   = wave_sh_q;
    freq_sh_d   = freq_sh_q;
    amp_sh_d    = amp_sh_q;
    wave_d      = wave_q;
    freq_d      = freq_q;
    amp_d       = amp_q;
    cfg_valid_d = 1'b0;
    last_up_d   = last_up_q;
    gap_d       = (gap_q < ACCEL_WIN) ? gap_q + 24'd1 : ACCEL_WIN;

    if (acc_mode) begin
      gap_d = ACCEL_WIN;
      case (state_q)
        FOCUS_WAVE: state_d = FOCUS_FREQ;
        FOCUS_FREQ: state_d = FOCUS_AMP;
        default:    state_d = FOCUS_WAVE;
      endcase
    end else if (acc_ok) begin
      if (dirty_q) begin
        wave_d      = wave_sh_q;
        freq_d      = freq_sh_q;
        amp_d       = amp_sh_q;
        cfg_valid_d = 1'b1;
      end
    end else if (acc_up || acc_dn) begin
      case (state_q)
        FOCUS_WAVE: wave_sh_d = acc_up ? wave_sh_q + 2'd1 : wave_sh_q - 2'd1;
        FOCUS_FREQ: begin
          freq_sh_d = freq_step;
          gap_d     = '0;
          // A pinned edit leaves the direction record alone.
          if (freq_step != freq_sh_q) last_up_d = acc_up;
        end
        default: begin
          if (acc_up && amp_sh_q != 4'd15) amp_sh_d = amp_sh_q + 4'd1;
          if (acc_dn && amp_sh_q != 4'd0)  amp_sh_d = amp_sh_q - 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FOCUS_WAVE;
      wave_sh_q   <= '0;
      freq_sh_q   <= FREQ_INIT;
      amp_sh_q    <= 4'd8;
      wave_q      <= '0;
      freq_q      <= FREQ_INIT;
      amp_q       <= 4'd8;
      dirty_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      gap_q       <= ACCEL_WIN;
      last_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wave_sh_q   <= wave_sh_d;
      freq_sh_q   <= freq_sh_d;
      amp_sh_q    <= amp_sh_d;
      wave_q      <= wave_d;
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      dirty_q     <= (wave_sh_d != wave_d) || (freq_sh_d != freq_d) || (amp_sh_d != amp_d);
      cfg_valid_q <= cfg_valid_d;
      gap_q       <= gap_d;
      last_up_q   <= last_up_d;
    end
  end

  assign bus.wave_sel  = wave_q;
  assign bus.freq_word = freq_q;
  assign bus.amp       = amp_q;
  assign bus.focus     = state_q;
  assign bus.dirty     = dirty_q;
  assign bus.cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_btn_cfg_sequencer.sv
// Directed bench for btn_cfg_sequencer: event table plus hand sequences for
// amplitude saturation, mid-edit reset and frequency saturation at both ends.
module tb_btn_cfg_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_mode = 1'b0, ev_ok = 1'b0, ev_up = 1'b0, ev_down = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  btn_cfg_sequencer_if #(.FREQ_W(16)) if_main ();
  btn_cfg_sequencer_if #(.FREQ_W(16)) if_hi ();
  btn_cfg_sequencer_if #(.FREQ_W(16)) if_lo ();

  assign if_main.ev_mode = ev_mode;
  assign if_main.ev_ok   = ev_ok;
  assign if_main.ev_up   = ev_up;
  assign if_main.ev_down = ev_down;
  assign if_hi.ev_mode   = ev_mode;
  assign if_hi.ev_ok     = ev_ok;
  assign if_hi.ev_up     = ev_up;
  assign if_hi.ev_down   = ev_down;
  assign if_lo.ev_mode   = ev_mode;
  assign if_lo.ev_ok     = ev_ok;
  assign if_lo.ev_up     = ev_up;
  assign if_lo.ev_down   = ev_down;

  btn_cfg_sequencer u_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
  btn_cfg_sequencer #(.FREQ_INIT(16'd49995)) u_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi));
  btn_cfg_sequencer #(.FREQ_INIT(16'd12))    u_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo));

  typedef struct {
    logic        m, o, u, d;
    int unsigned idle;
    logic [1:0]  w;
    logic [15:0] f;
    logic [3:0]  a;
    logic [1:0]  foc;
    logic        dty, cv;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input logic [1:0] w, input logic [15:0] f,
                          input logic [3:0] a, input logic [1:0] foc,
                          input logic dty, input logic cv);
    chk({nm, ".wave_sel"},  32'(if_main.wave_sel),  32'(w));
    chk({nm, ".freq_word"}, 32'(if_main.freq_word), 32'(f));
    chk({nm, ".amp"},       32'(if_main.amp),       32'(a));
    chk({nm, ".focus"},     32'(if_main.focus),     32'(foc));
    chk({nm, ".dirty"},     32'(if_main.dirty),     32'(dty));
    chk({nm, ".cfg_valid"}, 32'(if_main.cfg_valid), 32'(cv));
  endtask

  // Drive one cycle of events, then sample 1 time unit after the capturing edge.
  task automatic step(input logic m, input logic o, input logic u, input logic d);
    ev_mode = m; ev_ok = o; ev_up = u; ev_down = d;
    @(posedge clk);
    #1;
    ev_mode = 1'b0; ev_ok = 1'b0; ev_up = 1'b0; ev_down = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    //            m     o     u     d    idle w     f           a     foc   dty   cv
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2'd0, 16'd1000, 4'd8, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2'd3, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2'd3, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2'd3, 16'd1000, 4'd8, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2'd3, 16'd1000, 4'd8, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2'd3, 16'd1000, 4'd8, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2'd3, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2'd3, 16'd1000, 4'd8, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9, 2'd3, 16'd1000, 4'd8, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9, 2'd3, 16'd1000, 4'd8, 2'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2'd3, 16'd1000, 4'd8, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2'd3, 16'd1090, 4'd8, 2'd1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2'd3, 16'd1090, 4'd8, 2'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2'd3, 16'd1090, 4'd8, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2'd3, 16'd1090, 4'd8, 2'd1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2'd3, 16'd1080, 4'd8, 2'd1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2'd3, 16'd1080, 4'd8, 2'd2, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 2'd3, 16'd1080, 4'd8, 2'd2, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2'd3, 16'd1080, 4'd8, 2'd0, 1'b0, 1'b0};

    idle(1);
    chk_main("reset_held", 2'd0, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk_main("reset_released", 2'd0, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].m, tbl[i].o, tbl[i].u, tbl[i].d);
      chk_main($sformatf("vec%0d", i), tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].foc, tbl[i].dty, tbl[i].cv);
      if (tbl[i].idle != 0) idle(tbl[i].idle);
    end

    // Amplitude saturates at 15 after ten presses from 8, then one commit.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
    end
    chk_main("amp_pending", 2'd3, 16'd1080, 4'd8, 2'd2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_main("amp_commit", 2'd3, 16'd1080, 4'd15, 2'd2, 1'b0, 1'b1);
    idle(1);
    chk_main("amp_cv_drop", 2'd3, 16'd1080, 4'd15, 2'd2, 1'b0, 1'b0);

    // Reset asserted mid-edit clears outputs at once and discards the shadow.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_main("pre_reset_edit", 2'd3, 16'd1080, 4'd15, 2'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("async_reset", 2'd0, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    idle(2);
    chk_main("post_reset", 2'd0, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_main("ok_after_reset", 2'd0, 16'd1000, 4'd8, 2'd0, 1'b0, 1'b0);

    // Upper frequency limit on u_hi (starts at 49995).
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hi_dirty", 32'(if_hi.dirty), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hi_freq", 32'(if_hi.freq_word), 32'd50000);
    chk("hi_cv", 32'(if_hi.cfg_valid), 32'd1);
    chk("lo_freq_up", 32'(if_lo.freq_word), 32'd22);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hi_sat_dirty", 32'(if_hi.dirty), 32'd0);
    chk("hi_sat_freq", 32'(if_hi.freq_word), 32'd50000);

    // Lower frequency limit on u_lo (starts at 12).
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lo_freq", 32'(if_lo.freq_word), 32'd10);
    chk("lo_cv", 32'(if_lo.cfg_valid), 32'd1);
    chk("hi_freq_dn", 32'(if_hi.freq_word), 32'd49985);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lo_sat_dirty", 32'(if_lo.dirty), 32'd0);
    chk("lo_sat_freq", 32'(if_lo.freq_word), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
